change_dispense_ctrl: RTL and testbench

//  Sequences coin payout after a sale or cancel. On start, latches the refund amount
//  (Q1 fixed point: value = yuan*2, matching the vending FSM coin_sum encoding).

---
 rtl/change_dispense_ctrl_pkg.sv | 18 +
 rtl/change_dispense_ctrl_if.sv | 31 +++
 rtl/change_dispense_ctrl_hop.sv | 62 ++++++
 rtl/change_dispense_ctrl.sv | 135 +++++++++++++
 tb/tb_change_dispense_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/change_dispense_ctrl_pkg.sv
// Shared vending constants: Q1 coin values (0.5-yuan units), amount width, payout state encoding.
// Pure declarations; no timing or flow control of its own.
package change_dispense_ctrl_pkg;

    localparam int AMT_W_DEF     = 6;
    localparam int BIG_VAL_DEF   = 2;
    localparam int SMALL_VAL_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_REQ,
        ST_REL,
        ST_DONE,
        ST_ERR
    } pay_state_t;

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Payout controller <-> vending FSM / hopper bus; master = controller side.
// Hopper req/ack are 4-phase; start/clear/done are single-cycle pulses.
interface change_dispense_ctrl_if
    import change_dispense_ctrl_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF
);
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             big_empty;
    logic             small_empty;
    logic             big_ack;
    logic             small_ack;
    logic             big_req;
    logic             small_req;
    logic             busy;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] owed;
    logic             clear;

    modport master (
        input  start, amount, big_empty, small_empty, big_ack, small_ack, clear,
        output big_req, small_req, busy, done, err, owed
    );

    modport slave (
        output start, amount, big_empty, small_empty, big_ack, small_ack, clear,
        input  big_req, small_req, busy, done, err, owed
    );
endinterface

// File: rtl/change_dispense_ctrl_hop.sv
// One 4-phase hopper channel: req rises the cycle after go, falls on ack; released once ack drops.
// Waits indefinitely for ack unless CHANGE_TIMEOUT_EN adds a TIMEOUT_CYC abort.
module change_dispense_ctrl_hop
`ifdef CHANGE_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 1024
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic ack,
    output logic req,
    output logic acked,
    output logic released,
    output logic timeout
);
    logic wait_rel;

    assign acked    = req & ack;
    assign released = wait_rel & ~ack;

`ifdef CHANGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Fires on the last cycle of the window so req is high for exactly TIMEOUT_CYC cycles.
    assign timeout = req & ~ack & (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (go) begin
            wait_cnt <= '0;
        end else if (req && !ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req      <= 1'b0;
            wait_rel <= 1'b0;
        end else begin
            if (go) begin
                req <= 1'b1;
            end else if (acked || timeout) begin
                req <= 1'b0;
            end

            if (acked) begin
                wait_rel <= 1'b1;
            end else if (released) begin
                wait_rel <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/change_dispense_ctrl.sv
// Pays out owed change one coin at a time (big first), >=3 cycles per coin; done pulses 2 cycles after a zero start.
// Stalls in REQ until hopper ack; empty tubes lead to sticky err. CHANGE_TIMEOUT_EN adds a req timeout.
module change_dispense_ctrl
    import change_dispense_ctrl_pkg::*;
#(
    parameter int AMT_W     = AMT_W_DEF,
    parameter int BIG_VAL   = BIG_VAL_DEF,
    parameter int SMALL_VAL = SMALL_VAL_DEF
`ifdef CHANGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    change_dispense_ctrl_if.master bus
);
    pay_state_t       state, state_nxt;
    logic [AMT_W-1:0] owed_q, owed_nxt;
    logic             sel_big, sel_big_nxt;
    logic             go_big, go_small;
    logic             big_acked, big_released, big_timeout;
    logic             small_acked, small_released, small_timeout;
    logic             pay_big, pay_small;
    logic             coin_acked, coin_released, coin_timeout;
    logic [AMT_W-1:0] coin_val;

    change_dispense_ctrl_hop
`ifdef CHANGE_TIMEOUT_EN
        #(.TIMEOUT_CYC(TIMEOUT_CYC))
`endif
    u_big_hop (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go_big),
        .ack      (bus.big_ack),
        .req      (bus.big_req),
        .acked    (big_acked),
        .released (big_released),
        .timeout  (big_timeout)
    );

    change_dispense_ctrl_hop
`ifdef CHANGE_TIMEOUT_EN
        #(.TIMEOUT_CYC(TIMEOUT_CYC))
`endif
    u_small_hop (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go_small),
        .ack      (bus.small_ack),
        .req      (bus.small_req),
        .acked    (small_acked),
        .released (small_released),
        .timeout  (small_timeout)
    );

    // Only the channel picked in SEL may advance the FSM; the other channel's ack is ignored.
    assign pay_big       = (owed_q >= AMT_W'(BIG_VAL)) && !bus.big_empty;
    assign pay_small     = (owed_q >= AMT_W'(SMALL_VAL)) && !bus.small_empty;
    assign coin_acked    = sel_big ? big_acked    : small_acked;
    assign coin_released = sel_big ? big_released : small_released;
    assign coin_timeout  = sel_big ? big_timeout  : small_timeout;
    assign coin_val      = sel_big ? AMT_W'(BIG_VAL) : AMT_W'(SMALL_VAL);

    always_comb begin
        state_nxt   = state;
        owed_nxt    = owed_q;
        sel_big_nxt = sel_big;
        go_big      = 1'b0;
        go_small    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    owed_nxt  = bus.amount;
                    state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                if (owed_q == '0) begin
                    state_nxt = ST_DONE;
                end else if (pay_big) begin
                    go_big      = 1'b1;
                    sel_big_nxt = 1'b1;
                    state_nxt   = ST_REQ;
                end else if (pay_small) begin
                    go_small    = 1'b1;
                    sel_big_nxt = 1'b0;
                    state_nxt   = ST_REQ;
                end else begin
                    state_nxt = ST_ERR;
                end
            end
            ST_REQ: begin
                if (coin_acked) begin
                    owed_nxt  = owed_q - coin_val;
                    state_nxt = ST_REL;
                end else if (coin_timeout) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_REL: begin
                if (coin_released) begin
                    state_nxt = ST_SEL;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR: begin
                if (bus.clear) begin
                    owed_nxt  = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            owed_q  <= '0;
            sel_big <= 1'b0;
        end else begin
            state   <= state_nxt;
            owed_q  <= owed_nxt;
            sel_big <= sel_big_nxt;
        end
    end

    assign bus.owed = owed_q;
    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);
    assign bus.err  = (state == ST_ERR);
endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl with a coin scoreboard: expected (coin, owed) pushed per start,
// observed entries captured at each req rising edge.
module tb_change_dispense_ctrl;
    localparam int AMT_W = 6;

    logic clk;
    logic rst_n;
    logic hop_en;
    int   n_vec;
    int   n_err;
    int   done_cnt;
    logic saw_big;
    logic saw_small;
    int   exp_q[$];
    int   obs_q[$];

    change_dispense_ctrl_if #(.AMT_W(AMT_W)) bus();

    change_dispense_ctrl #(
        .AMT_W(AMT_W)
`ifdef CHANGE_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hopper models: ack two cycles after req, drop ack once req drops.
    initial begin : big_hopper
        int cnt;
        cnt = 0;
        bus.big_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.big_ack = 1'b0;
                cnt = 0;
            end else if (bus.big_ack) begin
                if (!bus.big_req) bus.big_ack = 1'b0;
            end else if (bus.big_req && hop_en) begin
                cnt++;
                if (cnt >= 2) begin
                    bus.big_ack = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : small_hopper
        int cnt;
        cnt = 0;
        bus.small_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.small_ack = 1'b0;
                cnt = 0;
            end else if (bus.small_ack) begin
                if (!bus.small_req) bus.small_ack = 1'b0;
            end else if (bus.small_req && hop_en) begin
                cnt++;
                if (cnt >= 2) begin
                    bus.small_ack = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: log coin type (256 = big) plus owed at each req rising edge; count done pulses.
    initial begin : monitor
        logic pb, ps;
        pb = 1'b0;
        ps = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.big_req && !pb) obs_q.push_back(256 + int'(bus.owed));
            if (bus.small_req && !ps) obs_q.push_back(int'(bus.owed));
            if (bus.big_req) saw_big = 1'b1;
            if (bus.small_req) saw_small = 1'b1;
            if (bus.done) done_cnt++;
            pb = bus.big_req;
            ps = bus.small_req;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        int e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            check({tag, "_coin"}, o, e);
        end
        check({tag, "_extra_coins"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    task automatic pulse_start(input int amt);
        @(negedge clk);
        bus.amount = AMT_W'(amt);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, found, 1'b1);
    endtask

    task automatic wait_big_req(input string tag, input int budget);
        logic found;
        found = bus.big_req;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            found = bus.big_req;
        end
        check({tag, "_big_req_seen"}, found, 1'b1);
    endtask

    task automatic clear_flags();
        done_cnt  = 0;
        saw_big   = 1'b0;
        saw_small = 1'b0;
    endtask

    initial begin : stim
        logic found;
        int   hi_cnt;
        n_vec = 0;
        n_err = 0;
        hop_en = 1'b1;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.amount = '0;
        bus.big_empty = 1'b0;
        bus.small_empty = 1'b0;
        bus.clear = 1'b0;
        clear_flags();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_big_req", bus.big_req, 0);
        check("rst_small_req", bus.small_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_owed", bus.owed, 0);

        // 3.5 yuan, both tubes full; a second start mid-payout must be ignored
        clear_flags();
        exp_q.push_back(256 + 7);
        exp_q.push_back(256 + 5);
        exp_q.push_back(256 + 3);
        exp_q.push_back(1);
        pulse_start(7);
        wait_big_req("amt7", 20);
        pulse_start(3);
        wait_done("amt7", 200);
        @(negedge clk);
        check("amt7_done_cnt", done_cnt, 1);
        check("amt7_owed", bus.owed, 0);
        check("amt7_err", bus.err, 0);
        check("amt7_busy", bus.busy, 0);
        sb_check("amt7");

        // Zero amount: done two cycles after start, no requests
        clear_flags();
        pulse_start(0);
        check("amt0_busy_sel", bus.busy, 1);
        check("amt0_done_early", bus.done, 0);
        @(negedge clk);
        check("amt0_done", bus.done, 1);
        @(negedge clk);
        check("amt0_done_len", bus.done, 0);
        check("amt0_busy_end", bus.busy, 0);
        check("amt0_no_req", saw_big | saw_small, 0);
        sb_check("amt0");

        // Big tube empty: six small coins
        clear_flags();
        bus.big_empty = 1'b1;
        for (int k = 6; k >= 1; k--) exp_q.push_back(k);
        pulse_start(6);
        wait_done("amt6", 300);
        @(negedge clk);
        check("amt6_no_big", saw_big, 0);
        check("amt6_owed", bus.owed, 0);
        check("amt6_done_cnt", done_cnt, 1);
        sb_check("amt6");
        bus.big_empty = 1'b0;

        // Small tube empty, odd amount: two big coins then stall with owed=1
        clear_flags();
        bus.small_empty = 1'b1;
        exp_q.push_back(256 + 5);
        exp_q.push_back(256 + 3);
        pulse_start(5);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = bus.err;
        end
        check("amt5_err_seen", found, 1);
        check("amt5_owed", bus.owed, 1);
        check("amt5_busy", bus.busy, 1);
        check("amt5_no_done", done_cnt, 0);
        repeat (3) @(negedge clk);
        check("amt5_err_sticky", bus.err, 1);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("amt5_clr_err", bus.err, 0);
        check("amt5_clr_owed", bus.owed, 0);
        check("amt5_clr_busy", bus.busy, 0);
        sb_check("amt5");
        bus.small_empty = 1'b0;

        // Hopper never acks
        clear_flags();
        hop_en = 1'b0;
        exp_q.push_back(256 + 2);
        pulse_start(2);
`ifdef CHANGE_TIMEOUT_EN
        hi_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.big_req) hi_cnt++;
            else if (hi_cnt > 0) break;
        end
        check("tmo_req_cycles", hi_cnt, 16);
        check("tmo_err", bus.err, 1);
        check("tmo_owed", bus.owed, 2);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("tmo_clr_err", bus.err, 0);
        sb_check("tmo");
        exp_q.push_back(256 + 4);
        pulse_start(4);
        wait_big_req("rst", 10);
`else
        wait_big_req("hang", 10);
        hi_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.big_req) hi_cnt++;
        end
        check("hang_req_held", hi_cnt, 1000);
        check("hang_err", bus.err, 0);
        check("hang_busy", bus.busy, 1);
`endif

        // Asynchronous reset mid-handshake
        #2 rst_n = 1'b0;
        #1;
        check("arst_big_req", bus.big_req, 0);
        check("arst_owed", bus.owed, 0);
        check("arst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hop_en = 1'b1;
        sb_check("arst");

        // Mixed payout after recovery
        clear_flags();
        exp_q.push_back(256 + 3);
        exp_q.push_back(1);
        pulse_start(3);
        wait_done("amt3", 200);
        @(negedge clk);
        check("amt3_owed", bus.owed, 0);
        sb_check("amt3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
